// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin two-requester sequencer in front of a 1W/2R register file.
// Clears every register after reset, then runs one read or write transaction at a time.
`default_nettype none

module regfile_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_sel_i,
    input  logic [DW-1:0] a_wdata,
    input  logic [AW-1:0] a_sel_o1,
    input  logic [AW-1:0] a_sel_o2,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_sel_i,
    input  logic [DW-1:0] b_wdata,
    input  logic [AW-1:0] b_sel_o1,
    input  logic [AW-1:0] b_sel_o2,
    output logic          a_rsp_valid,
    output logic          b_rsp_valid,
    output logic [DW-1:0] rsp_d1,
    output logic [DW-1:0] rsp_d2,
    output logic          init_done,
    output logic [DW-1:0] Ip1,
    output logic [AW-1:0] sel_i1,
    output logic [AW-1:0] sel_o1,
    output logic [AW-1:0] sel_o2,
    output logic          EN,
    output logic          WR,
    output logic          RD,
    input  logic [DW-1:0] Op1,
    input  logic [DW-1:0] Op2
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_CMD  = 3'd2,
        S_WACK = 3'd3,
        S_CAPT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;     // 0 = A has priority, 1 = B
    logic          win_q, win_d;       // side owning the transaction in flight
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic [AW-1:0] seli_q, seli_d;
    logic [AW-1:0] selo1_q, selo1_d;
    logic [AW-1:0] selo2_q, selo2_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;
    logic          grant_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            seli_q  <= '0;
            selo1_q <= '0;
            selo2_q <= '0;
            wdata_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            we_q    <= we_d;
            done_q  <= done_d;
            seli_q  <= seli_d;
            selo1_q <= selo1_d;
            selo2_q <= selo2_d;
            wdata_q <= wdata_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        win_d       = win_q;
        we_d        = we_q;
        done_d      = done_q;
        seli_d      = seli_q;
        selo1_d     = selo1_q;
        selo2_d     = selo2_q;
        wdata_d     = wdata_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        Ip1         = '0;
        sel_i1      = '0;
        sel_o1      = '0;
        sel_o2      = '0;
        EN          = 1'b0;
        WR          = 1'b0;
        RD          = 1'b0;
        grant_b     = b_valid & (~a_valid | prio_q);

        case (state_q)
            S_INIT: begin
                // Gated by rst so the clear write is not driven while reset is held.
                EN     = rst;
                WR     = rst;
                sel_i1 = cnt_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_IDLE: begin
                if (a_valid | b_valid) begin
                    a_ready = ~grant_b;
                    b_ready = grant_b;
                    win_d   = grant_b;
                    prio_d  = ~grant_b;
                    we_d    = grant_b ? b_we     : a_we;
                    seli_d  = grant_b ? b_sel_i  : a_sel_i;
                    wdata_d = grant_b ? b_wdata  : a_wdata;
                    selo1_d = grant_b ? b_sel_o1 : a_sel_o1;
                    selo2_d = grant_b ? b_sel_o2 : a_sel_o2;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                EN      = 1'b1;
                WR      = we_q;
                RD      = ~we_q;
                Ip1     = wdata_q;
                sel_i1  = seli_q;
                sel_o1  = selo1_q;
                sel_o2  = selo2_q;
                state_d = we_q ? S_WACK : S_CAPT;
            end
            S_WACK: begin
                a_rsp_valid = ~win_q;
                b_rsp_valid = win_q;
                state_d     = S_IDLE;
            end
            S_CAPT: begin
                rd1_d   = Op1;
                rd2_d   = Op2;
                state_d = S_RESP;
            end
            S_RESP: begin
                a_rsp_valid = ~win_q;
                b_rsp_valid = win_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign rsp_d1    = rd1_q;
    assign rsp_d2    = rd2_q;
    assign init_done = done_q;

endmodule

`default_nettype wire
